ecc_177_err_mgr: RTL and testbench
==================================

ECC_177_ERR_MGR -- requirements
Module: ecc_177_err_mgr

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, width of the error counters.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 16, width of the self-test period counter.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-005 SHALL have port rd_vld, input, 1: decoder result valid this cycle.
REQ-006 SHALL have ports sbit_err, dbit_err, ecc_fault, input, 1 each: flags from the dual-redundant ECC 177 checker, qualified by rd_vld.
REQ-007 SHALL have port cfg_en, input, 1: manager enable.
REQ-008 SHALL have port cfg_thr, input, CNT_WIDTH: single-bit-error interrupt threshold.
REQ-009 SHALL have port cfg_period, input, PERIOD_WIDTH: idle cycles between self-tests; 0 disables self-test.
REQ-010 SHALL have port clr, input, 1: pulse that clears counters, status and irq.
REQ-011 SHALL have port test_gnt, input, 1: datapath grants a self-test read slot.
REQ-012 SHALL have port fault_detc_en, output, 1: drives the checker's redundant-compare enable.
REQ-013 SHALL have port test_req, output, 1: requests a self-test slot.
REQ-014 SHALL have ports inj_sbit and inj_dbit, output, 1 each: force a 1-bit or 2-bit corruption on the granted read.
REQ-015 SHALL have ports sbit_cnt and dbit_cnt, output, CNT_WIDTH each: saturating error counters.
REQ-016 SHALL have port status, output, 3: sticky bits {fault, dbit, test_fail}.
REQ-017 SHALL have port irq, output, 1: level interrupt.

Function
REQ-018 SHALL assert fault_detc_en = cfg_en, registered, one-cycle latency.
REQ-019 SHALL increment sbit_cnt and dbit_cnt on rd_vld with the respective flag while in MONITOR, saturating at all-ones with no wrap.
REQ-020 SHALL set status[2] on rd_vld & ecc_fault in any state and status[1] on rd_vld & dbit_err in MONITOR; bits stay set until clr.
REQ-021 SHALL assert irq when any status bit is set or when sbit_cnt >= cfg_thr with cfg_thr != 0; irq follows these conditions in the same cycle (combinational).
REQ-022 SHALL implement FSM states IDLE, MONITOR, REQ_S, CHK_S, REQ_D, CHK_D.
REQ-023 SHALL go IDLE->MONITOR when cfg_en = 1, and return from any state to IDLE when cfg_en = 0, deasserting test_req and inj_* the next cycle.
REQ-024 SHALL count idle cycles in MONITOR and go to REQ_S when the count reaches cfg_period with cfg_period != 0; the counter reloads on entry to MONITOR.
REQ-025 SHALL hold test_req high in REQ_S and REQ_D until test_gnt; on the test_gnt cycle it SHALL pulse inj_sbit or inj_dbit for exactly one cycle and move to CHK_S or CHK_D.
REQ-026 SHALL complete CHK_S on the first rd_vld, passing if sbit_err = 1 and dbit_err = 0, then go to REQ_D; any other result SHALL set status[0] and go to MONITOR.
REQ-027 SHALL complete CHK_D on the first rd_vld, passing if dbit_err = 1, then go to MONITOR; a failure SHALL set status[0].
REQ-028 SHALL exclude self-test reads from sbit_cnt, dbit_cnt and status[1].
REQ-029 SHALL fail a check (set status[0], go to MONITOR) if no rd_vld arrives within 15 cycles in CHK_*.
REQ-030 SHALL give priority to clr when clr and a counting event occur in the same cycle: counters are 0 afterwards and status is cleared; the FSM state is unaffected.

Reset
REQ-031 SHALL, while rst_n = 0 at a clk edge, set state to IDLE, all counters and status to 0, and all outputs to 0.
REQ-032 SHALL abort a self-test in progress on reset, with no injection pulse afterwards.

Configuration
REQ-033 SHALL compile the self-test FSM states and period counter only when macro ECC_ERR_MGR_SELFTEST_EN is defined.
REQ-034 SHALL, without ECC_ERR_MGR_SELFTEST_EN, tie test_req, inj_sbit, inj_dbit and status[0] to 0 and use only IDLE and MONITOR.

Structure
REQ-035 SHALL place the FSM state enum, the check timeout constant (15) and the status bit indices in shared package ecc_err_mgr_pkg.
REQ-036 SHALL contain one sub-module, ecc_err_sat_cnt (saturating counter with clear), instantiated twice.

Verification
REQ-037 SHALL check: cfg_en = 1, cfg_period = 0, ten rd_vld with sbit_err -> sbit_cnt = 10; with cfg_thr = 10, irq = 1.
REQ-038 SHALL check: CNT_WIDTH = 8, 300 sbit_err reads -> sbit_cnt = 255; then clr in the same cycle as an error -> sbit_cnt = 0.
REQ-039 SHALL check: cfg_period = 20, test_gnt 3 cycles after test_req, correct sbit and then dbit responses -> one inj_sbit pulse and one inj_dbit pulse, status = 0, counters unchanged.
REQ-040 SHALL check: in CHK_S, respond with sbit_err = 0 -> status[0] = 1, irq = 1, FSM returns to MONITOR.
REQ-041 SHALL check: a single rd_vld & ecc_fault -> status[2] = 1 and irq = 1 until clr.
REQ-042 SHALL check: cfg_en dropped while in REQ_D, or rst_n low in CHK_S -> next cycle test_req = 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/ecc_err_mgr_pkg.sv
// Shared types and constants for the ECC 177 error manager.
package ecc_err_mgr_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMonitor,
    StReqS,
    StChkS,
    StReqD,
    StChkD
  } err_mgr_state_e;

  // Cycles allowed in a check state before the self-test is declared failed.
  localparam int unsigned ChkTimeout = 15;

  localparam int unsigned StatFault    = 2;
  localparam int unsigned StatDbit     = 1;
  localparam int unsigned StatTestFail = 0;

endpackage

// File: rtl/ecc_err_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module ecc_err_sat_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ecc_177_err_mgr.sv
// ECC 177 error manager: error counters, sticky status and irq for the redundant checker.
// Periodic checker self-test is built only when ECC_ERR_MGR_SELFTEST_EN is defined.
module ecc_177_err_mgr
  import ecc_err_mgr_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_vld,
  input  logic                    sbit_err,
  input  logic                    dbit_err,
  input  logic                    ecc_fault,
  input  logic                    cfg_en,
  input  logic [CNT_WIDTH-1:0]    cfg_thr,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  input  logic                    clr,
  input  logic                    test_gnt,
  output logic                    fault_detc_en,
  output logic                    test_req,
  output logic                    inj_sbit,
  output logic                    inj_dbit,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [2:0]              status,
  output logic                    irq
);

  err_mgr_state_e state_q, state_d;
  logic [2:0]     status_q, status_d;
  logic           fde_q;
  logic           in_mon, sbit_inc, dbit_inc;

  // Only functional reads seen in MONITOR are counted; self-test reads land in CHK states.
  assign in_mon   = (state_q == StMonitor);
  assign sbit_inc = rd_vld & sbit_err & in_mon;
  assign dbit_inc = rd_vld & dbit_err & in_mon;

  ecc_err_sat_cnt #(
    .Width(CNT_WIDTH)
  ) u_sbit_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (sbit_inc),
    .cnt  (sbit_cnt)
  );

  ecc_err_sat_cnt #(
    .Width(CNT_WIDTH)
  ) u_dbit_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (dbit_inc),
    .cnt  (dbit_cnt)
  );

`ifdef ECC_ERR_MGR_SELFTEST_EN
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [3:0]              tmo_q, tmo_d;
  logic                    tmo_hit;

  assign tmo_hit = (tmo_q == 4'(ChkTimeout - 1));
`else
  logic unused_selftest;
  assign unused_selftest = ^{test_gnt, cfg_period};
`endif

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    test_req = 1'b0;
    inj_sbit = 1'b0;
    inj_dbit = 1'b0;

    if (rd_vld && ecc_fault) status_d[StatFault] = 1'b1;
    if (dbit_inc)            status_d[StatDbit]  = 1'b1;

`ifdef ECC_ERR_MGR_SELFTEST_EN
    test_req = (state_q == StReqS) || (state_q == StReqD);
`endif

    if (!cfg_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StMonitor;
        StMonitor: begin
`ifdef ECC_ERR_MGR_SELFTEST_EN
          if ((cfg_period != '0) && (period_q >= cfg_period - 1'b1)) state_d = StReqS;
`endif
        end
`ifdef ECC_ERR_MGR_SELFTEST_EN
        StReqS: begin
          if (test_gnt) begin
            inj_sbit = 1'b1;
            state_d  = StChkS;
          end
        end
        StChkS: begin
          if (rd_vld && sbit_err && !dbit_err) begin
            state_d = StReqD;
          end else if (rd_vld || tmo_hit) begin
            status_d[StatTestFail] = 1'b1;
            state_d                = StMonitor;
          end
        end
        StReqD: begin
          if (test_gnt) begin
            inj_dbit = 1'b1;
            state_d  = StChkD;
          end
        end
        StChkD: begin
          if (rd_vld || tmo_hit) begin
            if (!(rd_vld && dbit_err)) status_d[StatTestFail] = 1'b1;
            state_d = StMonitor;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end

    // Clear wins over any same-cycle status event; the FSM itself is left alone.
    if (clr) status_d = '0;

`ifdef ECC_ERR_MGR_SELFTEST_EN
    period_d = (in_mon && (state_d == StMonitor)) ? period_q + 1'b1 : '0;
    tmo_d    = (state_d == state_q) ? tmo_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      status_q <= '0;
      fde_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      fde_q    <= cfg_en;
    end
  end

`ifdef ECC_ERR_MGR_SELFTEST_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_q <= '0;
      tmo_q    <= '0;
    end else begin
      period_q <= period_d;
      tmo_q    <= tmo_d;
    end
  end
`endif

  assign fault_detc_en = fde_q;
  assign status        = status_q;
  assign irq           = (|status_q) || ((cfg_thr != '0) && (sbit_cnt >= cfg_thr));

endmodule

// File: tb/tb_ecc_177_err_mgr.sv
// Bench for ecc_177_err_mgr: reference model feeds a scoreboard queue, a negedge monitor
// compares. Self-test scenarios are added when ECC_ERR_MGR_SELFTEST_EN is defined.
module tb_ecc_177_err_mgr;

  localparam int CW   = 8;
  localparam int PW   = 16;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ECC_ERR_MGR_SELFTEST_EN
  localparam bit SELFTEST = 1'b1;
`else
  localparam bit SELFTEST = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rd_vld, sbit_err, dbit_err, ecc_fault, cfg_en, clr, test_gnt;
  logic [CW-1:0] cfg_thr;
  logic [PW-1:0] cfg_period;
  logic          fault_detc_en, test_req, inj_sbit, inj_dbit, irq;
  logic [CW-1:0] sbit_cnt, dbit_cnt;
  logic [2:0]    status;

  ecc_177_err_mgr #(
    .CNT_WIDTH   (CW),
    .PERIOD_WIDTH(PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_vld       (rd_vld),
    .sbit_err     (sbit_err),
    .dbit_err     (dbit_err),
    .ecc_fault    (ecc_fault),
    .cfg_en       (cfg_en),
    .cfg_thr      (cfg_thr),
    .cfg_period   (cfg_period),
    .clr          (clr),
    .test_gnt     (test_gnt),
    .fault_detc_en(fault_detc_en),
    .test_req     (test_req),
    .inj_sbit     (inj_sbit),
    .inj_dbit     (inj_dbit),
    .sbit_cnt     (sbit_cnt),
    .dbit_cnt     (dbit_cnt),
    .status       (status),
    .irq          (irq)
  );

  typedef struct {
    string      name;
    int         sb;
    int         db;
    logic [2:0] st;
    logic       irq;
    logic       fde;
    bit         chk_tr;
    logic       tr;
    int         inj_s;
    int         inj_d;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: error totals, sticky flags, and whether the manager is monitoring.
  int         m_sb = 0, m_db = 0;
  logic [2:0] m_st = '0;
  bit         m_mon = 1'b0, m_fde = 1'b0;

  // Per-step annotations from the scenario code.
  bit    st_rd = 1'b0, tfail = 1'b0, chk_tr = 1'b0;
  logic  exp_tr = 1'b0;
  int    exp_inj_s = 0, exp_inj_d = 0;
  int    seen_inj_s = 0, seen_inj_d = 0;
  string phase = "reset";

  function automatic void chk(input string what, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", what, act, req, $time);
    end
  endfunction

  always @(posedge clk) begin
    if (inj_sbit === 1'b1) seen_inj_s <= seen_inj_s + 1;
    if (inj_dbit === 1'b1) seen_inj_d <= seen_inj_d + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, " sbit_cnt"}, int'(sbit_cnt), e.sb);
      chk({e.name, " dbit_cnt"}, int'(dbit_cnt), e.db);
      chk({e.name, " status"}, int'(status), int'(e.st));
      chk({e.name, " irq"}, int'(irq), int'(e.irq));
      chk({e.name, " fault_detc_en"}, int'(fault_detc_en), int'(e.fde));
      chk({e.name, " inj_sbit pulses"}, seen_inj_s, e.inj_s);
      chk({e.name, " inj_dbit pulses"}, seen_inj_d, e.inj_d);
      if (e.chk_tr) chk({e.name, " test_req"}, int'(test_req), int'(e.tr));
    end
  end

  // One clock: model consumes the inputs sampled at this edge, expectation is queued.
  task automatic step();
    exp_t e;
    @(posedge clk);
    if (!rst_n) begin
      m_sb = 0; m_db = 0; m_st = '0; m_mon = 1'b0; m_fde = 1'b0;
    end else begin
      m_fde = cfg_en;
      if (rd_vld && ecc_fault) m_st[2] = 1'b1;
      if (m_mon && rd_vld && !st_rd) begin
        if (sbit_err) m_sb = (m_sb < CMAX) ? m_sb + 1 : CMAX;
        if (dbit_err) begin
          m_db = (m_db < CMAX) ? m_db + 1 : CMAX;
          m_st[1] = 1'b1;
        end
      end
      if (tfail) m_st[0] = 1'b1;
      if (clr) begin
        m_sb = 0; m_db = 0; m_st = '0;
      end
      m_mon = cfg_en;
    end
    e.name   = phase;
    e.sb     = m_sb;
    e.db     = m_db;
    e.st     = m_st;
    e.irq    = (|m_st) || ((cfg_thr != '0) && (m_sb >= int'(cfg_thr)));
    e.fde    = m_fde;
    e.chk_tr = chk_tr || !SELFTEST;
    e.tr     = chk_tr ? exp_tr : 1'b0;
    e.inj_s  = exp_inj_s;
    e.inj_d  = exp_inj_d;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    st_rd  = 1'b0;
    tfail  = 1'b0;
    chk_tr = 1'b0;
  endtask

`ifdef ECC_ERR_MGR_SELFTEST_EN
  task automatic wait_treq(input int lim);
    int n = 0;
    while (test_req !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    chk({phase, " test_req within bound"}, int'(test_req === 1'b1), 1);
  endtask

  task automatic grant(input bit is_d);
    test_gnt = 1'b1;
    if (is_d) exp_inj_d++;
    else exp_inj_s++;
    chk_tr = 1'b1;
    exp_tr = 1'b0;
    step();
    test_gnt = 1'b0;
  endtask

  task automatic respond(input bit s, input bit d, input bit fail, input bit tr_after);
    rd_vld = 1'b1; sbit_err = s; dbit_err = d;
    st_rd = 1'b1; tfail = fail; chk_tr = 1'b1; exp_tr = tr_after;
    step();
    rd_vld = 1'b0; sbit_err = 1'b0; dbit_err = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; rd_vld = 1'b0; sbit_err = 1'b0; dbit_err = 1'b0; ecc_fault = 1'b0;
    cfg_en = 1'b0; clr = 1'b0; test_gnt = 1'b0; cfg_thr = '0; cfg_period = '0;
    step();
    step();

    // Ten single-bit errors reach a threshold of ten.
    phase = "thr10";
    rst_n = 1'b1; cfg_en = 1'b1; cfg_thr = CW'(10);
    step();
    for (int i = 0; i < 10; i++) begin
      rd_vld = 1'b1; sbit_err = 1'b1;
      step();
    end
    rd_vld = 1'b0; sbit_err = 1'b0;
    step();

    phase = "rand";
    for (int i = 0; i < 250; i++) begin
      rd_vld    = ($urandom_range(0, 3) != 0);
      sbit_err  = 1'($urandom_range(0, 1));
      dbit_err  = ($urandom_range(0, 3) == 0);
      ecc_fault = ($urandom_range(0, 31) == 0);
      clr       = ($urandom_range(0, 15) == 0);
      cfg_en    = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 31) == 0) cfg_thr = CW'($urandom_range(0, 20));
      step();
    end
    rd_vld = 1'b0; sbit_err = 1'b0; dbit_err = 1'b0; ecc_fault = 1'b0; clr = 1'b0;
    cfg_en = 1'b1; cfg_thr = '0;
    step();

    phase = "saturate";
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rd_vld = 1'b1; sbit_err = 1'b1;
      step();
    end
    phase = "clr_vs_err";
    clr = 1'b1;
    step();
    clr = 1'b0; rd_vld = 1'b0; sbit_err = 1'b0;
    step();

    phase = "fault_sticky";
    rd_vld = 1'b1; ecc_fault = 1'b1;
    step();
    rd_vld = 1'b0; ecc_fault = 1'b0;
    repeat (5) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();

    phase = "disabled";
    cfg_en = 1'b0;
    step();
    rd_vld = 1'b1; sbit_err = 1'b1; dbit_err = 1'b1;
    repeat (3) step();
    rd_vld = 1'b0; sbit_err = 1'b0; dbit_err = 1'b0;
    step();

`ifdef ECC_ERR_MGR_SELFTEST_EN
    phase = "st_pass";
    rst_n = 1'b0; cfg_en = 1'b0; cfg_period = PW'(20);
    step();
    rst_n = 1'b1; cfg_en = 1'b1;
    wait_treq(40);
    chk_tr = 1'b1; exp_tr = 1'b1;
    step();
    chk_tr = 1'b1; exp_tr = 1'b1;
    step();
    grant(1'b0);
    respond(1'b1, 1'b0, 1'b0, 1'b1);
    grant(1'b1);
    respond(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();

    phase = "st_fail";
    wait_treq(40);
    grant(1'b0);
    respond(1'b0, 1'b0, 1'b1, 1'b0);
    chk_tr = 1'b1; exp_tr = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;

    phase = "st_timeout";
    wait_treq(40);
    grant(1'b0);
    for (int i = 0; i < 15; i++) begin
      tfail = (i == 14);
      chk_tr = 1'b1; exp_tr = 1'b0;
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;

    phase = "st_disable";
    wait_treq(40);
    grant(1'b0);
    respond(1'b1, 1'b0, 1'b0, 1'b1);
    cfg_en = 1'b0; chk_tr = 1'b1; exp_tr = 1'b0;
    step();
    rd_vld = 1'b1; sbit_err = 1'b1;
    step();
    rd_vld = 1'b0; sbit_err = 1'b0; cfg_en = 1'b1;
    step();

    phase = "st_reset";
    wait_treq(40);
    grant(1'b0);
    rst_n = 1'b0; chk_tr = 1'b1; exp_tr = 1'b0;
    step();
    rst_n = 1'b1; test_gnt = 1'b1;
    repeat (5) begin
      chk_tr = 1'b1; exp_tr = 1'b0;
      step();
    end
    test_gnt = 1'b0;
    step();
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
